// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with an occupancy counter; shared by the UART transmitter and receiver.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usage
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally at AW bits; the extra counter bit tells full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign usage = cnt;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1/8E1 serialiser with a registered line output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY_EN   = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [UART_DATA_BITS-1:0]     data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   usage_o
);
    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    uart_tx_state_e             state;
    logic [CW-1:0]              baud_cnt;
    logic [2:0]                 bit_idx;
    logic [UART_DATA_BITS-1:0]  shreg;
    logic                       par_bit;
    logic                       baud_end;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic [UART_DATA_BITS-1:0]  head;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (valid_i),
        .wdata  (data_i),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .usage  (usage_o)
    );

    assign baud_end = (baud_cnt == LAST_CNT);
    // Popping at the last stop cycle lets the next start bit follow with no idle gap.
    assign pop      = !empty && ((state == IDLE) || (state == STOP && baud_end));
    assign ready_o  = !full;
    assign busy_o   = (state != IDLE) || !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_o     <= 1'b1;
        end else begin
            baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= ^head;
                        state   <= START;
                        tx_o    <= 1'b0;
                    end
                end
                START: if (baud_end) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx_o    <= shreg[0];
                end
                DATA: if (baud_end) begin
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state <= PARITY;
                            tx_o  <= par_bit;
                        end else begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        shreg   <= shreg >> 1;
                        tx_o    <= shreg[1];
                    end
                end
                PARITY: if (baud_end) begin
                    state <= STOP;
                    tx_o  <= 1'b1;
                end
                STOP: if (baud_end) begin
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= ^head;
                        state   <= START;
                        tx_o    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one 8N1 and one 8E1 instance checked cycle-by-cycle against a frame model.
`timescale 1ns/1ps

module tb_uart_tx;
    localparam int CLK_HZ = 1_152_000;
    localparam int BAUD   = 115200;
    localparam int DIV    = 10;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       rdy0, rdy1, tx0, tx1, busy0, busy1;
    logic [3:0] use0, use1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d0), .valid_i(v0),
        .ready_o(rdy0), .tx_o(tx0), .busy_o(busy0), .usage_o(use0));

    uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d1), .valid_i(v1),
        .ready_o(rdy1), .tx_o(tx1), .busy_o(busy1), .usage_o(use1));

    always #434 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txv(input bit p);
        return p ? tx1 : tx0;
    endfunction

    function automatic logic rdyv(input bit p);
        return p ? rdy1 : rdy0;
    endfunction

    function automatic logic frame_bit(input bit p, input logic [7:0] b, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        if (p && s == 9) return (($countones(b) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic push(input bit p, input logic [7:0] b);
        int w = 0;
        if (p) begin d1 = b; v1 = 1'b1; end
        else   begin d0 = b; v0 = 1'b1; end
        while (!rdyv(p) && w < 5000) begin
            if (!p) chk("ready_low_only_when_full", use0, 4'd8);
            @(negedge clk);
            w++;
        end
        chk("push_timeout", (w < 5000), 1'b1);
        @(posedge clk);
        if (p) q1.push_back(b); else q0.push_back(b);
        @(negedge clk);
        if (p) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_start(input bit p, input int budget, output int w);
        w = 0;
        while (txv(p) === 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", txv(p), 1'b0);
    endtask

    task automatic check_frame(input bit p, input string tag);
        logic [7:0] b;
        int nb;
        logic e, obs;
        nb = p ? 11 : 10;
        if (p) begin
            chk("model_queue_nonempty", (q1.size() > 0), 1'b1);
            b = (q1.size() > 0) ? q1.pop_front() : 8'h00;
        end else begin
            chk("model_queue_nonempty", (q0.size() > 0), 1'b1);
            b = (q0.size() > 0) ? q0.pop_front() : 8'h00;
        end
        for (int s = 0; s < nb; s++) begin
            e = frame_bit(p, b, s);
            obs = e;
            for (int c = 0; c < DIV; c++) begin
                if (txv(p) !== e) obs = txv(p);
                @(negedge clk);
            end
            chk(tag, obs, e);
        end
    endtask

    initial begin
        int w, t0, tstart, trans, nfull;
        logic last;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("reset_idle", {tx0, rdy0, busy0, use0, tx1, rdy1, busy1, use1}, {3'b110, 4'd0, 3'b110, 4'd0});
        end

        push(0, 8'h41);
        chk("after_push_tx_still_idle", tx0, 1'b1);
        chk("after_push_usage", use0, 4'd1);
        chk("after_push_busy", busy0, 1'b1);
        @(negedge clk);
        chk("latency_start_bit", tx0, 1'b0);
        t0 = cyc;
        check_frame(0, "frame_0x41");
        chk("frame_len_8n1", cyc - t0, 100);
        chk("busy_after_frame", busy0, 1'b0);
        chk("tx_idle_after_frame", tx0, 1'b1);

        push(1, 8'h07);
        push(1, 8'h03);
        chk("parity_first_start", tx1, 1'b0);
        t0 = cyc;
        check_frame(1, "frame_0x07_par");
        chk("frame_len_8e1", cyc - t0, 110);
        check_frame(1, "frame_0x03_par");
        chk("busy_after_parity", busy1, 1'b0);

        nfull = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) push(0, 8'(i));
            end
            begin
                wait_start(0, 200, w);
                t0 = cyc;
                for (int i = 0; i < 12; i++) check_frame(0, "burst_frame");
                chk("burst_total_cycles", cyc - t0, 1200);
                chk("burst_busy_end", busy0, 1'b0);
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (use0 == 4'd8) begin
                        nfull++;
                        chk("ready_when_full", rdy0, 1'b0);
                    end
                end
            end
        join
        chk("burst_reached_full", (nfull > 0), 1'b1);

        fork
            begin
                push(0, 8'h55); push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3);
            end
            begin
                wait_start(0, 50, w);
                tstart = cyc;
            end
        join
        while (cyc < tstart + 45) @(negedge clk);
        chk("pre_reset_bit3", tx0, 1'b0);
        chk("pre_reset_queued", use0, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_async", tx0, 1'b1);
        chk("rst_usage", use0, 4'd0);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        trans = 0;
        last = tx0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx0 !== last) trans++;
            last = tx0;
        end
        chk("no_tx_after_reset", trans, 0);
        chk("idle_after_reset", {tx0, busy0, use0}, {2'b10, 4'd0});

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 150)) @(negedge clk);
                    push(1, 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    wait_start(1, 3000, w);
                    check_frame(1, "random_frame");
                end
            end
        join
        chk("random_queue_drained", q1.size(), 0);
        chk("random_busy_end", busy1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
